// File: rtl/serdes_pkg.sv
// Shared serdes definitions: FSM state encoding and counter sizing helper.
// Used by both the word serializer and the word deserializer.
package serdes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Ceiling log2 with a floor of 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/serial_word_deserializer_if.sv
// Link-side and consumer-side signals of the word deserializer.
// Optional SERDES_PARITY_EN adds the parity_err_o pulse.
interface serial_word_deserializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             sof_i;
  logic             bit_valid_i;
  logic             bit_i;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             overrun_o;
  logic             busy_o;
`ifdef SERDES_PARITY_EN
  logic             parity_err_o;

  modport master (output sof_i, bit_valid_i, bit_i, ready_i,
                  input  data_o, valid_o, overrun_o, busy_o, parity_err_o);
  modport slave  (input  sof_i, bit_valid_i, bit_i, ready_i,
                  output data_o, valid_o, overrun_o, busy_o, parity_err_o);
`else
  modport master (output sof_i, bit_valid_i, bit_i, ready_i,
                  input  data_o, valid_o, overrun_o, busy_o);
  modport slave  (input  sof_i, bit_valid_i, bit_i, ready_i,
                  output data_o, valid_o, overrun_o, busy_o);
`endif
endinterface

// File: rtl/serdes_bit_counter.sv
// Modulo-MODULUS bit counter with clear, increment and terminal-count flag.
// clr_i together with inc_i loads 1, so a frame's first bit can be counted on the clear edge.
module serdes_bit_counter
  import serdes_pkg::*;
#(
  parameter int unsigned MODULUS = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_c
);
  localparam int unsigned CNT_W = clog2(MODULUS);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_c = (cnt_q == CNT_W'(MODULUS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? CNT_W'(1) : '0;
    end else if (inc_i) begin
      cnt_d = tc_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_word_deserializer.sv
// Collects WIDTH serial bits into a word and offers it on a valid/ready handshake.
// SERDES_PARITY_EN: frame carries a trailing even-parity bit that is checked, not stored.
module serial_word_deserializer
  import serdes_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  serial_word_deserializer_if.slave  bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] first_c, shifted_c, word_c;
  logic             cnt_clr_c, cnt_inc_c, cnt_tc_c, word_done_c;
`ifdef SERDES_PARITY_EN
  logic             perr_q, perr_d;
  logic             par_bad_c;
`endif

  serdes_bit_counter #(.MODULUS(WIDTH)) u_bit_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr_c),
    .inc_i  (cnt_inc_c),
    .tc_c   (cnt_tc_c)
  );

  // MSB_FIRST=0 shifts in from the top so the first bit ends up in bit 0.
  assign first_c   = MSB_FIRST ? WIDTH'(bus.bit_i) : (WIDTH'(bus.bit_i) << (WIDTH - 1));
  assign shifted_c = MSB_FIRST ? {shreg_q[WIDTH-2:0], bus.bit_i}
                               : {bus.bit_i, shreg_q[WIDTH-1:1]};
`ifdef SERDES_PARITY_EN
  assign word_c    = shreg_q;
`else
  assign word_c    = shifted_c;
`endif

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_clr_c   = 1'b0;
    cnt_inc_c   = 1'b0;
    word_done_c = 1'b0;
`ifdef SERDES_PARITY_EN
    par_bad_c   = 1'b0;
`endif
    if (bus.bit_valid_i) begin
      if (bus.sof_i) begin
        // Start of frame restarts from any state, abandoning a partial word.
        state_d   = ST_SHIFT;
        shreg_d   = first_c;
        cnt_clr_c = 1'b1;
        cnt_inc_c = 1'b1;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            shreg_d   = shifted_c;
            cnt_inc_c = 1'b1;
            if (cnt_tc_c) begin
`ifdef SERDES_PARITY_EN
              state_d     = ST_DONE;
`else
              state_d     = ST_IDLE;
              word_done_c = 1'b1;
`endif
            end
          end
          ST_DONE: begin
            state_d = ST_IDLE;
`ifdef SERDES_PARITY_EN
            word_done_c = (bus.bit_i == ^shreg_q);
            par_bad_c   = (bus.bit_i != ^shreg_q);
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // Output holding register: drop-and-flag when the previous word is still unread.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (valid_q && bus.ready_i) valid_d = 1'b0;
    if (word_done_c) begin
      if (!valid_q || bus.ready_i) begin
        data_d  = word_c;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    busy_d = (state_d != ST_IDLE);
`ifdef SERDES_PARITY_EN
    perr_d = par_bad_c;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SERDES_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
`ifdef SERDES_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign bus.data_o    = data_q;
  assign bus.valid_o   = valid_q;
  assign bus.overrun_o = overrun_q;
  assign bus.busy_o    = busy_q;
`ifdef SERDES_PARITY_EN
  assign bus.parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Scoreboard bench: MSB-first and LSB-first 8-bit instances plus a 2-bit instance.
// Honours SERDES_PARITY_EN when the build defines it.
module tb_serial_word_deserializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic sof, bv, bt, rdy;
  logic sof2, bv2, bt2, rdy2;

  serial_word_deserializer_if #(.WIDTH(8)) if_m ();
  serial_word_deserializer_if #(.WIDTH(8)) if_l ();
  serial_word_deserializer_if #(.WIDTH(2)) if_2 ();

  assign if_m.sof_i = sof;  assign if_m.bit_valid_i = bv;  assign if_m.bit_i = bt;  assign if_m.ready_i = rdy;
  assign if_l.sof_i = sof;  assign if_l.bit_valid_i = bv;  assign if_l.bit_i = bt;  assign if_l.ready_i = rdy;
  assign if_2.sof_i = sof2; assign if_2.bit_valid_i = bv2; assign if_2.bit_i = bt2; assign if_2.ready_i = rdy2;

  serial_word_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (.clk_i(clk), .rst_ni(rst_n), .bus(if_m));
  serial_word_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (.clk_i(clk), .rst_ni(rst_n), .bus(if_l));
  serial_word_deserializer #(.WIDTH(2), .MSB_FIRST(1'b1)) u_2 (.clk_i(clk), .rst_ni(rst_n), .bus(if_2));

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  logic [1:0] q_2[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends the first n bits of w, MSB first, as the start of a frame.
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      sof = (i == 0); bv = 1'b1; bt = w[7-i];
      tick();
    end
    sof = 1'b0; bv = 1'b0;
  endtask

  // Full 8-bit frame; stall_at inserts two idle cycles after that bit index.
  task automatic send8(input logic [7:0] w, input bit push, input bit par_ok, input int stall_at);
    if (push && par_ok) begin
      q_m.push_back(w);
      q_l.push_back(rev8(w));
    end
    for (int i = 0; i < 8; i++) begin
      sof = (i == 0); bv = 1'b1; bt = w[7-i];
      tick();
      if (i == stall_at) begin
        sof = 1'b0; bv = 1'b0; bt = 1'b1;
        tick();
        tick();
      end
    end
`ifdef SERDES_PARITY_EN
    sof = 1'b0; bv = 1'b1; bt = par_ok ? ^w : ~(^w);
    tick();
`endif
    sof = 1'b0; bv = 1'b0;
  endtask

  // 2-bit frame; rdy_last raises ready together with the completing bit.
  task automatic send2(input logic [1:0] w, input bit rdy_last);
    q_2.push_back(w);
    sof2 = 1'b1; bv2 = 1'b1; bt2 = w[1];
    tick();
    sof2 = 1'b0; bt2 = w[0];
`ifdef SERDES_PARITY_EN
    tick();
    bt2 = ^w;
`endif
    if (rdy_last) rdy2 = 1'b1;
    tick();
    bv2 = 1'b0;
  endtask

  // Scoreboard: each handshake pops one expected word.
  always @(negedge clk) begin
    if (rst_n && if_m.valid_o && if_m.ready_i) begin
      if (q_m.size() == 0) chk("m_extra_word", 64'(if_m.valid_o), 64'd0);
      else                 chk("m_word", 64'(if_m.data_o), 64'(q_m.pop_front()));
    end
    if (rst_n && if_l.valid_o && if_l.ready_i) begin
      if (q_l.size() == 0) chk("l_extra_word", 64'(if_l.valid_o), 64'd0);
      else                 chk("l_word", 64'(if_l.data_o), 64'(q_l.pop_front()));
    end
    if (rst_n && if_2.valid_o && if_2.ready_i) begin
      if (q_2.size() == 0) chk("w2_extra_word", 64'(if_2.valid_o), 64'd0);
      else                 chk("w2_word", 64'(if_2.data_o), 64'(q_2.pop_front()));
    end
  end

  initial begin
    sof = 0; bv = 0; bt = 0; rdy = 0;
    sof2 = 0; bv2 = 0; bt2 = 0; rdy2 = 0;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_data",    64'(if_m.data_o),    64'd0);
    chk("rst_valid",   64'(if_m.valid_o),   64'd0);
    chk("rst_overrun", 64'(if_m.overrun_o), 64'd0);
    chk("rst_busy",    64'(if_m.busy_o),    64'd0);
    rst_n = 1'b1;
    tick();

    // Basic frame, 1-cycle latency, single-cycle valid.
    rdy = 1'b1;
    send8(8'hA5, 1, 1, -1);
    chk("t1_valid_lat", 64'(if_m.valid_o), 64'd1);
    chk("t1_data",      64'(if_m.data_o),  64'hA5);
    chk("t1_busy_done", 64'(if_m.busy_o),  64'd0);
    tick();
    chk("t1_valid_1clk", 64'(if_m.valid_o), 64'd0);

    // LSB-first ordering and a mid-frame stall.
    send8(8'h01, 1, 1, -1);
    chk("t2_l_data", 64'(if_l.data_o), 64'h80);
    chk("t2_m_data", 64'(if_m.data_o), 64'h01);
    send8(8'h96, 1, 1, 3);
    chk("t2_stall_l", 64'(if_l.data_o), 64'h69);
    tick();

    // Overrun: second word dropped while the first is held.
    rdy = 1'b0;
    send8(8'h3C, 1, 1, -1);
    send8(8'hFF, 0, 1, -1);
    tick();
    chk("t3_held_data", 64'(if_m.data_o),    64'h3C);
    chk("t3_held_l",    64'(if_l.data_o),    64'h3C);
    chk("t3_valid",     64'(if_m.valid_o),   64'd1);
    chk("t3_overrun",   64'(if_m.overrun_o), 64'd1);
    rdy = 1'b1;
    tick(); tick();
    chk("t3_sticky",    64'(if_m.overrun_o), 64'd1);
    chk("t3_cleared",   64'(if_m.valid_o),   64'd0);

    // Restart: partial word abandoned by a new sof.
    send_bits(8'hF0, 4);
    chk("t4_busy", 64'(if_m.busy_o), 64'd1);
    send8(8'h5A, 1, 1, -1);
    chk("t4_data", 64'(if_m.data_o), 64'h5A);
    tick();

    // Reset mid-frame.
    send_bits(8'hFF, 5);
    chk("t5_busy_pre", 64'(if_m.busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_data",    64'(if_m.data_o),    64'd0);
    chk("t5_rst_valid",   64'(if_m.valid_o),   64'd0);
    chk("t5_rst_overrun", 64'(if_m.overrun_o), 64'd0);
    chk("t5_rst_busy",    64'(if_m.busy_o),    64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send8(8'hC3, 1, 1, -1);
    chk("t5_data", 64'(if_m.data_o), 64'hC3);
    tick();

`ifdef SERDES_PARITY_EN
    // Parity: bad parity drops the word and pulses the error.
    send8(8'h07, 0, 0, -1);
    chk("t6_perr_pulse", 64'(if_m.parity_err_o), 64'd1);
    chk("t6_no_valid",   64'(if_m.valid_o),      64'd0);
    tick();
    chk("t6_perr_1clk",  64'(if_m.parity_err_o), 64'd0);
    send8(8'h07, 1, 1, -1);
    chk("t6_good_valid", 64'(if_m.valid_o),      64'd1);
    chk("t6_good_perr",  64'(if_m.parity_err_o), 64'd0);
    tick();
`endif

    // WIDTH=2 frames and handshake/completion on the same edge.
    rdy2 = 1'b1;
    send2(2'b10, 0);
    chk("w2_data", 64'(if_2.data_o), 64'd2);
    tick();
    rdy2 = 1'b0;
    send2(2'b11, 0);
    chk("w2_held", 64'(if_2.valid_o), 64'd1);
    send2(2'b01, 1);
    chk("w2_nobubble_valid", 64'(if_2.valid_o),   64'd1);
    chk("w2_nobubble_data",  64'(if_2.data_o),    64'd1);
    chk("w2_no_overrun",     64'(if_2.overrun_o), 64'd0);
    tick();
    chk("w2_drained", 64'(if_2.valid_o), 64'd0);

    tick(); tick();
    chk("q_m_empty", 64'(q_m.size()), 64'd0);
    chk("q_l_empty", 64'(q_l.size()), 64'd0);
    chk("q_2_empty", 64'(q_2.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
